// File: rtl/mem_wb_pkg.sv
// Shared opcode encodings, FSM states and decode helpers for the MEM/WB stage.
// No logic of its own: only types, constants and pure functions.
// Imported by mem_wb and its load/store alignment sub-module.
package mem_wb_pkg;

  localparam int MEM_OP_W      = 4;
  localparam int DEST_SRC_W    = 2;
  localparam int DEF_ADDR_W    = 32;
  localparam int DEF_WORD_W    = 32;
  localparam int DEF_REG_IDX_W = 5;

  typedef enum logic [MEM_OP_W-1:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [DEST_SRC_W-1:0] {
    DEST_NONE = 2'd0,
    DEST_ALU  = 2'd1,
    DEST_MEM  = 2'd2,
    DEST_PC4  = 2'd3
  } dest_src_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  function automatic logic op_is_load(input logic [MEM_OP_W-1:0] op);
    return op inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
  endfunction

  function automatic logic op_is_store(input logic [MEM_OP_W-1:0] op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

endpackage

// File: rtl/mem_wb_load_store_align.sv
// Byte-lane steering: store enables/replication, misalignment check, load extract/extend.
// Purely combinational, zero latency.
// No flow control; the parent decides when the results are used.
module mem_wb_load_store_align
  import mem_wb_pkg::*;
(
  input  logic [MEM_OP_W-1:0] st_op_i,
  input  logic [1:0]          st_addr_lo_i,
  input  logic [31:0]         st_data_i,
  input  logic [MEM_OP_W-1:0] ld_op_i,
  input  logic [1:0]          ld_addr_lo_i,
  input  logic [31:0]         rdata_i,
  output logic [3:0]          be_o,
  output logic [31:0]         wdata_o,
  output logic                misaligned_o,
  output logic [31:0]         ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Request side: byte enables, replicated write data and alignment check for the incoming op.
  always_comb begin
    be_o         = 4'b0000;
    wdata_o      = st_data_i;
    misaligned_o = 1'b0;
    case (st_op_i)
      MEM_SB: begin
        be_o    = 4'b0001 << st_addr_lo_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      MEM_SH: begin
        be_o         = 4'b0011 << {st_addr_lo_i[1], 1'b0};
        wdata_o      = {2{st_data_i[15:0]}};
        misaligned_o = st_addr_lo_i[0];
      end
      MEM_SW: begin
        be_o         = 4'b1111;
        misaligned_o = |st_addr_lo_i;
      end
      MEM_LH, MEM_LHU: misaligned_o = st_addr_lo_i[0];
      MEM_LW:          misaligned_o = |st_addr_lo_i;
      default: ;
    endcase
  end

  // Response side: pick the addressed lane of the read word and extend it.
  always_comb begin
    case (ld_addr_lo_i)
      2'd0:    ld_byte = rdata_i[7:0];
      2'd1:    ld_byte = rdata_i[15:8];
      2'd2:    ld_byte = rdata_i[23:16];
      default: ld_byte = rdata_i[31:24];
    endcase
    ld_half = ld_addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (ld_op_i)
      MEM_LB:  ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      MEM_LBU: ld_data_o = {24'd0, ld_byte};
      MEM_LH:  ld_data_o = {{16{ld_half[15]}}, ld_half};
      MEM_LHU: ld_data_o = {16'd0, ld_half};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_wb.sv
// Memory-access + writeback stage: issues load/store on a req/ack bus, writes the register file.
// Non-memory ops write back 1 cycle after acceptance; loads 1 cycle after the ack edge.
// o_stall holds upstream while a bus transaction waits for ack (or a deferred writeback drains).
module mem_wb
  import mem_wb_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int WORD_W    = DEF_WORD_W,
  parameter int REG_IDX_W = DEF_REG_IDX_W
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  clr,
  input  logic [ADDR_W-1:0]     i_pc,
  input  logic [WORD_W-1:0]     i_alu_result,
  input  logic [WORD_W-1:0]     i_store_data,
  input  logic [MEM_OP_W-1:0]   i_mem_op,
  input  logic [DEST_SRC_W-1:0] i_dest_src,
  input  logic [REG_IDX_W-1:0]  i_dest_reg,
  output logic                  o_stall,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [3:0]            o_mem_be,
  output logic [WORD_W-1:0]     o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [WORD_W-1:0]     i_mem_rdata,
  output logic                  o_wb_dest_en,
  output logic [REG_IDX_W-1:0]  o_wb_dest_reg,
  output logic [WORD_W-1:0]     o_wb_dest_data,
  output logic                  o_fault
);

  state_e                state_q, state_d;
  logic                  req_q, req_d, we_q, we_d, kill_q, kill_d, fault_q, fault_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [3:0]            be_q, be_d;
  logic [WORD_W-1:0]     wdata_q, wdata_d;
  logic [MEM_OP_W-1:0]   op_q, op_d;
  logic [1:0]            lo_q, lo_d;
  logic                  ld_en_q, ld_en_d;
  logic [REG_IDX_W-1:0]  ld_reg_q, ld_reg_d;
  logic                  wb_en_q, wb_en_d, dfr_en_q, dfr_en_d;
  logic [REG_IDX_W-1:0]  wb_reg_q, wb_reg_d, dfr_reg_q, dfr_reg_d;
  logic [WORD_W-1:0]     wb_data_q, wb_data_d, dfr_data_q, dfr_data_d;

  logic                  busy, take, in_mem, start, done, nw_en, lw_en;
  logic [WORD_W-1:0]     nw_data;
  logic [3:0]            al_be;
  logic [WORD_W-1:0]     al_wdata, al_ld_data;
  logic                  al_mis;

  mem_wb_load_store_align u_align (
    .st_op_i      (i_mem_op),
    .st_addr_lo_i (i_alu_result[1:0]),
    .st_data_i    (i_store_data),
    .ld_op_i      (op_q),
    .ld_addr_lo_i (lo_q),
    .rdata_i      (i_mem_rdata),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .misaligned_o (al_mis),
    .ld_data_o    (al_ld_data)
  );

  // A non-memory op accepted on the ack edge of a load collides with the load's
  // writeback; it is parked in the deferred slot and upstream is held one extra cycle.
  assign busy    = (state_q == ST_BUSY);
  assign o_stall = (busy & ~i_mem_ack) | dfr_en_q;
  assign take    = ~o_stall & ~clr;
  assign in_mem  = (i_mem_op != MEM_NONE);
  assign start   = take & in_mem & ~al_mis;
  assign done    = busy & i_mem_ack;
  assign nw_en   = take & ~in_mem & (i_dest_reg != '0) &
                   ((i_dest_src == DEST_ALU) | (i_dest_src == DEST_PC4));
  assign nw_data = (i_dest_src == DEST_PC4) ? WORD_W'(i_pc + ADDR_W'(4)) : i_alu_result;
  assign lw_en   = done & ld_en_q & ~kill_q & ~clr;

  // Next state, bus request latching and writeback selection.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    op_d       = op_q;
    lo_d       = lo_q;
    ld_en_d    = ld_en_q;
    ld_reg_d   = ld_reg_q;
    kill_d     = kill_q;
    fault_d    = take & in_mem & al_mis;
    wb_en_d    = 1'b0;
    wb_reg_d   = wb_reg_q;
    wb_data_d  = wb_data_q;
    dfr_en_d   = dfr_en_q;
    dfr_reg_d  = dfr_reg_q;
    dfr_data_d = dfr_data_q;

    if (start) begin
      state_d  = ST_BUSY;
      req_d    = 1'b1;
      we_d     = op_is_store(i_mem_op);
      addr_d   = {i_alu_result[ADDR_W-1:2], 2'b00};
      be_d     = al_be;
      wdata_d  = al_wdata;
      op_d     = i_mem_op;
      lo_d     = i_alu_result[1:0];
      ld_en_d  = op_is_load(i_mem_op) & (i_dest_src != DEST_NONE) & (i_dest_reg != '0);
      ld_reg_d = i_dest_reg;
      kill_d   = 1'b0;
    end else if (done) begin
      state_d = ST_IDLE;
      req_d   = 1'b0;
    end else if (busy && clr) begin
      kill_d = 1'b1;
    end

    if (lw_en) begin
      wb_en_d   = 1'b1;
      wb_reg_d  = ld_reg_q;
      wb_data_d = al_ld_data;
      if (nw_en) begin
        dfr_en_d   = 1'b1;
        dfr_reg_d  = i_dest_reg;
        dfr_data_d = nw_data;
      end
    end else if (nw_en) begin
      wb_en_d   = 1'b1;
      wb_reg_d  = i_dest_reg;
      wb_data_d = nw_data;
    end else if (dfr_en_q) begin
      wb_en_d   = ~clr;
      wb_reg_d  = dfr_reg_q;
      wb_data_d = dfr_data_q;
      dfr_en_d  = 1'b0;
    end
  end

  // FSM state register; reset abandons any outstanding transaction.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Bus, pending-load and writeback registers.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      req_q <= 1'b0; we_q <= 1'b0; addr_q <= '0; be_q <= '0; wdata_q <= '0;
      op_q <= '0; lo_q <= '0; ld_en_q <= 1'b0; ld_reg_q <= '0; kill_q <= 1'b0;
      fault_q <= 1'b0; wb_en_q <= 1'b0; wb_reg_q <= '0; wb_data_q <= '0;
      dfr_en_q <= 1'b0; dfr_reg_q <= '0; dfr_data_q <= '0;
    end else begin
      req_q <= req_d; we_q <= we_d; addr_q <= addr_d; be_q <= be_d; wdata_q <= wdata_d;
      op_q <= op_d; lo_q <= lo_d; ld_en_q <= ld_en_d; ld_reg_q <= ld_reg_d; kill_q <= kill_d;
      fault_q <= fault_d; wb_en_q <= wb_en_d; wb_reg_q <= wb_reg_d; wb_data_q <= wb_data_d;
      dfr_en_q <= dfr_en_d; dfr_reg_q <= dfr_reg_d; dfr_data_q <= dfr_data_d;
    end
  end

  assign o_mem_req      = req_q;
  assign o_mem_we       = we_q;
  assign o_mem_addr     = addr_q;
  assign o_mem_be       = be_q;
  assign o_mem_wdata    = wdata_q;
  assign o_wb_dest_en   = wb_en_q;
  assign o_wb_dest_reg  = wb_reg_q;
  assign o_wb_dest_data = wb_data_q;
  assign o_fault        = fault_q;

endmodule

// File: tb/tb_mem_wb.sv
// Directed bench for mem_wb: hand-computed vectors, one checking task.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Bus ack is driven by the bench so no wait depends on the DUT.
module tb_mem_wb;
  import mem_wb_pkg::*;

  logic        clk = 1'b0;
  logic        aresetn, clr;
  logic [31:0] i_pc, i_alu_result, i_store_data;
  logic [3:0]  i_mem_op;
  logic [1:0]  i_dest_src;
  logic [4:0]  i_dest_reg;
  logic        o_stall, o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        o_wb_dest_en;
  logic [4:0]  o_wb_dest_reg;
  logic [31:0] o_wb_dest_data;
  logic        o_fault;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_wb dut (
    .clk(clk), .aresetn(aresetn), .clr(clr), .i_pc(i_pc), .i_alu_result(i_alu_result),
    .i_store_data(i_store_data), .i_mem_op(i_mem_op), .i_dest_src(i_dest_src),
    .i_dest_reg(i_dest_reg), .o_stall(o_stall), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
    .o_mem_addr(o_mem_addr), .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_wb_dest_en(o_wb_dest_en),
    .o_wb_dest_reg(o_wb_dest_reg), .o_wb_dest_data(o_wb_dest_data), .o_fault(o_fault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic present(input logic [3:0] op, input logic [1:0] src, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] sd, input logic [31:0] pc);
    i_mem_op = op; i_dest_src = src; i_dest_reg = rd;
    i_alu_result = alu; i_store_data = sd; i_pc = pc;
  endtask

  task automatic bubble();
    present(MEM_NONE, DEST_NONE, 5'd0, 32'd0, 32'd0, 32'd0);
  endtask

  // Single load with a given number of wait cycles before ack.
  task automatic do_load(input string nm, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] rdata, input int waits, input logic [31:0] exp);
    present(op, DEST_MEM, 5'd3, addr, 32'd0, 32'h40);
    step();
    bubble();
    for (int i = 0; i < waits; i++) begin
      sample();
      chk({nm, " req"},   o_mem_req,  32'd1);
      chk({nm, " addr"},  o_mem_addr, {addr[31:2], 2'b00});
      chk({nm, " be"},    o_mem_be,   32'd0);
      chk({nm, " we"},    o_mem_we,   32'd0);
      chk({nm, " stall"}, o_stall,    32'd1);
      step();
    end
    i_mem_ack = 1'b1; i_mem_rdata = rdata;
    sample();
    chk({nm, " stall@ack"}, o_stall, 32'd0);
    step();
    i_mem_ack = 1'b0;
    sample();
    chk({nm, " wb_en"},   o_wb_dest_en,   32'd1);
    chk({nm, " wb_reg"},  o_wb_dest_reg,  32'd3);
    chk({nm, " wb_data"}, o_wb_dest_data, exp);
    chk({nm, " req_off"}, o_mem_req,      32'd0);
    step();
    sample();
    chk({nm, " wb_once"}, o_wb_dest_en, 32'd0);
    step();
  endtask

  initial begin
    aresetn = 1'b0; clr = 1'b0; i_mem_ack = 1'b0; i_mem_rdata = '0;
    bubble();
    sample(); sample();
    chk("rst stall", o_stall, 32'd0);
    chk("rst req",   o_mem_req, 32'd0);
    chk("rst wb_en", o_wb_dest_en, 32'd0);
    chk("rst fault", o_fault, 32'd0);
    aresetn = 1'b1;
    step();

    // ALU writeback, one cycle only, never stalls
    present(MEM_NONE, DEST_ALU, 5'd5, 32'h1234, 32'd0, 32'h10);
    sample(); chk("alu stall", o_stall, 32'd0);
    step(); bubble();
    sample();
    chk("alu wb_en", o_wb_dest_en, 32'd1);
    chk("alu wb_reg", o_wb_dest_reg, 32'd5);
    chk("alu wb_data", o_wb_dest_data, 32'h1234);
    chk("alu stall2", o_stall, 32'd0);
    step(); sample();
    chk("alu once", o_wb_dest_en, 32'd0);
    step();

    // PC+4 wraps to zero
    present(MEM_NONE, DEST_PC4, 5'd1, 32'h0, 32'd0, 32'hFFFF_FFFC);
    step(); bubble(); sample();
    chk("pc4 wb_en", o_wb_dest_en, 32'd1);
    chk("pc4 data", o_wb_dest_data, 32'h0);
    step();

    // Sign / zero extended byte loads from lane 3, 3 wait cycles
    do_load("lb", MEM_LB, 32'h103, 32'h80FF_FF00, 3, 32'hFFFF_FF80);
    do_load("lbu", MEM_LBU, 32'h103, 32'h80FF_FF00, 3, 32'h0000_0080);
    do_load("lh", MEM_LH, 32'h102, 32'h8001_7F00, 0, 32'hFFFF_8001);

    // Halfword store at upper half
    present(MEM_SH, DEST_NONE, 5'd0, 32'h202, 32'hABCD_1234, 32'h50);
    step(); bubble(); sample();
    chk("sh req", o_mem_req, 32'd1);
    chk("sh we", o_mem_we, 32'd1);
    chk("sh addr", o_mem_addr, 32'h200);
    chk("sh be", o_mem_be, 32'hC);
    chk("sh wdata", o_mem_wdata, 32'h1234_1234);
    i_mem_ack = 1'b1;
    step(); i_mem_ack = 1'b0; sample();
    chk("sh no wb", o_wb_dest_en, 32'd0);
    chk("sh req off", o_mem_req, 32'd0);
    step();

    // Byte store at lane 1
    present(MEM_SB, DEST_NONE, 5'd0, 32'h301, 32'h0000_00A5, 32'h54);
    step(); bubble(); sample();
    chk("sb be", o_mem_be, 32'h2);
    chk("sb wdata", o_mem_wdata, 32'hA5A5_A5A5);
    i_mem_ack = 1'b1;
    step(); i_mem_ack = 1'b0;

    // Misaligned word load
    present(MEM_LW, DEST_MEM, 5'd6, 32'h101, 32'd0, 32'h58);
    step(); bubble(); sample();
    chk("mis fault", o_fault, 32'd1);
    chk("mis req", o_mem_req, 32'd0);
    chk("mis wb_en", o_wb_dest_en, 32'd0);
    chk("mis stall", o_stall, 32'd0);
    step(); sample();
    chk("mis pulse", o_fault, 32'd0);
    chk("mis req2", o_mem_req, 32'd0);
    step();

    // Back-to-back word loads, ack every cycle
    present(MEM_LW, DEST_MEM, 5'd8, 32'h300, 32'd0, 32'h60);
    step();
    present(MEM_LW, DEST_MEM, 5'd9, 32'h304, 32'd0, 32'h64);
    i_mem_ack = 1'b1; i_mem_rdata = 32'h1111_1111;
    sample();
    chk("b2b req1", o_mem_req, 32'd1);
    chk("b2b addr1", o_mem_addr, 32'h300);
    chk("b2b stall1", o_stall, 32'd0);
    step();
    bubble(); i_mem_rdata = 32'h2222_2222;
    sample();
    chk("b2b req2", o_mem_req, 32'd1);
    chk("b2b addr2", o_mem_addr, 32'h304);
    chk("b2b wb1 en", o_wb_dest_en, 32'd1);
    chk("b2b wb1 reg", o_wb_dest_reg, 32'd8);
    chk("b2b wb1 data", o_wb_dest_data, 32'h1111_1111);
    step();
    i_mem_ack = 1'b0;
    sample();
    chk("b2b req off", o_mem_req, 32'd0);
    chk("b2b wb2 en", o_wb_dest_en, 32'd1);
    chk("b2b wb2 reg", o_wb_dest_reg, 32'd9);
    chk("b2b wb2 data", o_wb_dest_data, 32'h2222_2222);
    step();

    // Flush while busy: transaction completes, writeback suppressed
    present(MEM_LW, DEST_MEM, 5'd7, 32'h400, 32'd0, 32'h70);
    step(); bubble(); clr = 1'b1;
    sample(); chk("clr req", o_mem_req, 32'd1);
    step(); clr = 1'b0;
    sample(); chk("clr req held", o_mem_req, 32'd1);
    i_mem_ack = 1'b1; i_mem_rdata = 32'hDEAD_BEEF;
    step(); i_mem_ack = 1'b0;
    sample();
    chk("clr no wb", o_wb_dest_en, 32'd0);
    chk("clr req off", o_mem_req, 32'd0);
    step();

    // ALU to x0 never writes
    present(MEM_NONE, DEST_ALU, 5'd0, 32'h55, 32'd0, 32'h74);
    step(); bubble(); sample();
    chk("x0 wb_en", o_wb_dest_en, 32'd0);
    step();

    // Flush in idle discards the presented op
    present(MEM_NONE, DEST_ALU, 5'd4, 32'h77, 32'd0, 32'h78);
    clr = 1'b1;
    step(); clr = 1'b0; bubble(); sample();
    chk("clr idle wb", o_wb_dest_en, 32'd0);
    step();

    // Async reset mid-transaction, late ack ignored
    present(MEM_LW, DEST_MEM, 5'd10, 32'h500, 32'd0, 32'h80);
    step(); bubble();
    aresetn = 1'b0;
    #1;
    chk("arst req", o_mem_req, 32'd0);
    chk("arst stall", o_stall, 32'd0);
    sample(); aresetn = 1'b1;
    i_mem_ack = 1'b1; i_mem_rdata = 32'h1234_5678;
    step(); i_mem_ack = 1'b0;
    sample();
    chk("arst late ack", o_wb_dest_en, 32'd0);
    chk("arst req2", o_mem_req, 32'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
